// File: rtl/time_set_controller_if.sv
// -----------------------------------------------------------------------------
// time_set_controller_if
// Bundles the signals between the timekeeping sequencing controller, its
// stimulus sources (1 Hz divider and button debouncers) and the counter bank.
//
//   Stimulus into the controller:
//     tick      one-cycle 1 Hz strobe
//     mode_btn  one-cycle debounced mode press
//     inc_btn   one-cycle debounced increment press
//   Counter feedback into the controller:
//     sec_cnt [5:0], min_cnt [5:0], hr_cnt [4:0], day_cnt [2:0]
//   Controller outputs:
//     sec_en, min_en, hr_en, day_en  one-cycle Up&Enable strobes
//     sec_clr                        one-cycle seconds clear request
//     mode [1:0]                     0=RUN 1=SET_DAY 2=SET_HR 3=SET_MIN
//     blink                          display blink for the field being set
//
// Modports: slave = the controller, master = whatever drives it.
// -----------------------------------------------------------------------------
interface time_set_controller_if;
  logic       tick;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] sec_cnt;
  logic [5:0] min_cnt;
  logic [4:0] hr_cnt;
  logic [2:0] day_cnt;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       day_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink;

  modport slave (
    input  tick, mode_btn, inc_btn, sec_cnt, min_cnt, hr_cnt, day_cnt,
    output sec_en, min_en, hr_en, day_en, sec_clr, mode, blink
  );

  modport master (
    output tick, mode_btn, inc_btn, sec_cnt, min_cnt, hr_cnt, day_cnt,
    input  sec_en, min_en, hr_en, day_en, sec_clr, mode, blink
  );
endinterface

// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
// Sequencing controller for the alarm-clock counters (sec 0-59, min 0-59,
// hr 0-23, day-of-week 0-6).
//   RUN      : each Tick issues a carry cascade of one-cycle enable strobes,
//              decided from the counter values fed back through the interface.
//   SET_*    : timekeeping frozen, Inc presses steer a single strobe to the
//              field being set, Tick toggles Blink.
//
// Ports:
//   i_clk   system clock, all logic on posedge
//   i_clr   synchronous active-high reset (overrides every other input)
//   i_bus   time_set_controller_if.slave (stimulus, counter feedback, outputs)
//
// All outputs are registered: strobes appear one cycle after their cause.
// -----------------------------------------------------------------------------
module time_set_controller #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23,
  parameter int DAY_MAX = 6
) (
  input  logic                        i_clk,
  input  logic                        i_clr,
  time_set_controller_if.slave        i_bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_DAY = 2'd1,
    ST_SET_HR  = 2'd2,
    ST_SET_MIN = 2'd3
  } state_t;

  state_t r_state;
  logic   r_sec_en;
  logic   r_min_en;
  logic   r_hr_en;
  logic   r_day_en;
  logic   r_sec_clr;
  logic   r_blink;

  state_t w_state_nxt;
  logic   w_sec_en_nxt;
  logic   w_min_en_nxt;
  logic   w_hr_en_nxt;
  logic   w_day_en_nxt;
  logic   w_sec_clr_nxt;
  logic   w_blink_nxt;

  logic   w_sec_term;
  logic   w_min_term;
  logic   w_hr_term;
  logic   w_day_term;

  // Exact-equality compare: out-of-range counter values never look terminal.
  assign w_sec_term = (i_bus.sec_cnt == 6'(SEC_MAX));
  assign w_min_term = (i_bus.min_cnt == 6'(MIN_MAX));
  assign w_hr_term  = (i_bus.hr_cnt  == 5'(HR_MAX));
  // Day wraps by itself; its terminal value is not needed for any strobe.
  assign w_day_term = (i_bus.day_cnt == 3'(DAY_MAX));

  // Next-state and next-output decode for the mode FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_sec_en_nxt  = 1'b0;
    w_min_en_nxt  = 1'b0;
    w_hr_en_nxt   = 1'b0;
    w_day_en_nxt  = 1'b0;
    w_sec_clr_nxt = 1'b0;
    w_blink_nxt   = r_blink;

    case (r_state)
      ST_RUN: begin
        w_blink_nxt = 1'b0;
        // The cascade is issued even when Mode_btn arrives in the same cycle.
        if (i_bus.tick) begin
          w_sec_en_nxt = 1'b1;
          w_min_en_nxt = w_sec_term;
          w_hr_en_nxt  = w_sec_term & w_min_term;
          w_day_en_nxt = w_sec_term & w_min_term & w_hr_term;
        end else begin
          w_sec_en_nxt = 1'b0;
        end
        if (i_bus.mode_btn) begin
          w_state_nxt = ST_SET_DAY;
          w_blink_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_SET_DAY, ST_SET_HR, ST_SET_MIN: begin
        if (i_bus.mode_btn) begin
          // Mode press wins: any Inc in this cycle is dropped.
          if (r_state == ST_SET_MIN) begin
            w_state_nxt   = ST_RUN;
            w_blink_nxt   = 1'b0;
            w_sec_clr_nxt = 1'b1;
          end else begin
            w_state_nxt = state_t'(r_state + 2'd1);
            w_blink_nxt = 1'b1;
          end
        end else begin
          if (i_bus.tick) begin
            w_blink_nxt = ~r_blink;
          end else begin
            w_blink_nxt = r_blink;
          end
          // Set increments never carry into the next field.
          if (i_bus.inc_btn) begin
            case (r_state)
              ST_SET_DAY: w_day_en_nxt = 1'b1;
              ST_SET_HR:  w_hr_en_nxt  = 1'b1;
              ST_SET_MIN: w_min_en_nxt = 1'b1;
              default:    w_day_en_nxt = 1'b0;
            endcase
          end else begin
            w_day_en_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
        w_blink_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state   <= ST_RUN;
      r_sec_en  <= 1'b0;
      r_min_en  <= 1'b0;
      r_hr_en   <= 1'b0;
      r_day_en  <= 1'b0;
      r_sec_clr <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec_en  <= w_sec_en_nxt;
      r_min_en  <= w_min_en_nxt;
      r_hr_en   <= w_hr_en_nxt;
      r_day_en  <= w_day_en_nxt;
      r_sec_clr <= w_sec_clr_nxt;
      r_blink   <= w_blink_nxt;
    end
  end

  assign i_bus.sec_en  = r_sec_en;
  assign i_bus.min_en  = r_min_en;
  assign i_bus.hr_en   = r_hr_en;
  assign i_bus.day_en  = r_day_en;
  assign i_bus.sec_clr = r_sec_clr;
  assign i_bus.mode    = r_state;
  assign i_bus.blink   = r_blink;

  // Terminal day value is decoded for completeness but drives nothing.
  logic w_unused;
  assign w_unused = w_day_term;

endmodule
